// File: rtl/pong_graph_dual.sv
// Pong playfield graphics: paddles, ball, serve/play/miss FSM and BCD scores; game state advances once per frame.
// Latency: graph_rgb one clk after pix inputs; no backpressure. Define PONG_ROUND_BALL_EN for a round 8x8 ball.
module pong_graph_dual #(
    parameter int H_PIXELS    = 640,
    parameter int V_PIXELS    = 480,
    parameter int BAR_Y_SIZE  = 72,
    parameter int BAR_V       = 4,
    parameter int BALL_SIZE   = 8,
    parameter int BALL_V      = 2,
    parameter int MISS_FRAMES = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       video_on,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic [3:0] btn,
    output logic [2:0] graph_rgb,
    output logic       hit,
    output logic       miss,
    output logic [3:0] score_l,
    output logic [3:0] score_r
);
    localparam int CW = $clog2(MISS_FRAMES + 1);
    localparam logic [9:0] L_X0     = 10'd32;
    localparam logic [9:0] L_X1     = 10'd35;
    localparam logic [9:0] R_X0     = 10'(H_PIXELS - 40);
    localparam logic [9:0] R_X1     = 10'(H_PIXELS - 37);
    localparam logic [9:0] BAR_MAX  = 10'(V_PIXELS - BAR_Y_SIZE);
    localparam logic [9:0] BAR_INIT = 10'((V_PIXELS - BAR_Y_SIZE) / 2);
    localparam logic [9:0] BAR_H    = 10'(BAR_Y_SIZE - 1);
    localparam logic [9:0] PV       = 10'(BAR_V);
    localparam logic [9:0] BV       = 10'(BALL_V);
    localparam logic [9:0] BALL_W   = 10'(BALL_SIZE - 1);
    localparam logic [9:0] BALL_X0  = 10'((H_PIXELS - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0  = 10'((V_PIXELS - BALL_SIZE) / 2);
    localparam logic [9:0] BOT_LIM  = 10'(V_PIXELS - 1 - BALL_V);
    localparam logic [9:0] R_MISS   = 10'(H_PIXELS - 1 - BALL_V);
    localparam logic [9:0] TICK_Y   = 10'(V_PIXELS + 1);

    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_MISS} state_t;

    state_t          state, state_nxt;
    logic [9:0]      x_l, y_t, x_nxt, y_nxt, bar_l, bar_r, bar_l_nxt, bar_r_nxt;
    logic            dir_r, dir_d, dx_nxt, dy_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [3:0]      sl_nxt, sr_nxt;
    logic            hit_nxt, miss_nxt;
    logic            refr_tick, overlap_l, overlap_r;
    logic [9:0]      x_r, y_b, bar_l_b, bar_r_b;
    logic            pad_on, ball_box, ball_on;
    logic [2:0]      rgb_nxt;

    assign refr_tick = (pix_y == TICK_Y) && (pix_x == 10'd0);
    assign x_r       = x_l + BALL_W;
    assign y_b       = y_t + BALL_W;
    assign bar_l_b   = bar_l + BAR_H;
    assign bar_r_b   = bar_r + BAR_H;
    assign overlap_l = (y_b >= bar_l) && (y_t <= bar_l_b);
    assign overlap_r = (y_b >= bar_r) && (y_t <= bar_r_b);

    function automatic logic [9:0] bar_step(input logic [9:0] top, input logic dn, input logic up);
        if (dn && !up)
            return (top > BAR_MAX - PV) ? BAR_MAX : top + PV;
        else if (up && !dn)
            return (top < PV) ? 10'd0 : top - PV;
        else
            return top;
    endfunction

    function automatic logic [3:0] bcd_inc(input logic [3:0] s);
        return (s == 4'd9) ? 4'd0 : s + 4'd1;
    endfunction

    always_comb begin
        state_nxt = state;
        x_nxt     = x_l;
        y_nxt     = y_t;
        dx_nxt    = dir_r;
        dy_nxt    = dir_d;
        cnt_nxt   = cnt;
        sl_nxt    = score_l;
        sr_nxt    = score_r;
        hit_nxt   = 1'b0;
        miss_nxt  = 1'b0;
        bar_l_nxt = bar_l;
        bar_r_nxt = bar_r;
        if (refr_tick) begin
            bar_l_nxt = bar_step(bar_l, btn[1], btn[0]);
            bar_r_nxt = bar_step(bar_r, btn[3], btn[2]);
            case (state)
                S_SERVE: begin
                    x_nxt  = BALL_X0;
                    y_nxt  = BALL_Y0;
                    dx_nxt = 1'b1;
                    dy_nxt = 1'b1;
                    if (|btn) state_nxt = S_PLAY;
                end
                S_PLAY: begin
                    // Vertical and horizontal decisions are independent so corner bounces apply both.
                    if (!dir_d && y_t <= BV)
                        dy_nxt = 1'b1;
                    else if (dir_d && y_b >= BOT_LIM)
                        dy_nxt = 1'b0;
                    if (dir_r && x_r >= R_X0 && x_r <= R_X1 && overlap_r) begin
                        dx_nxt  = 1'b0;
                        hit_nxt = 1'b1;
                    end else if (!dir_r && x_l >= L_X0 && x_l <= L_X1 && overlap_l) begin
                        dx_nxt  = 1'b1;
                        hit_nxt = 1'b1;
                    end else if (dir_r && x_r >= R_MISS) begin
                        miss_nxt  = 1'b1;
                        sl_nxt    = bcd_inc(score_l);
                        state_nxt = S_MISS;
                    end else if (!dir_r && x_l <= BV) begin
                        miss_nxt  = 1'b1;
                        sr_nxt    = bcd_inc(score_r);
                        state_nxt = S_MISS;
                    end
                    if (!miss_nxt) begin
                        x_nxt = dx_nxt ? x_l + BV : x_l - BV;
                        y_nxt = dy_nxt ? y_t + BV : y_t - BV;
                    end
                end
                S_MISS: begin
                    if (cnt == CW'(MISS_FRAMES - 1)) begin
                        cnt_nxt   = '0;
                        state_nxt = S_SERVE;
                        x_nxt     = BALL_X0;
                        y_nxt     = BALL_Y0;
                        dx_nxt    = 1'b1;
                        dy_nxt    = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: state_nxt = S_SERVE;
            endcase
        end
    end

    assign ball_box = (pix_x >= x_l) && (pix_x <= x_r) && (pix_y >= y_t) && (pix_y <= y_b);

`ifdef PONG_ROUND_BALL_EN
    logic [2:0] rom_row, rom_col;
    logic [7:0] rom_bits;
    assign rom_row = 3'(pix_y - y_t);
    assign rom_col = 3'(pix_x - x_l);
    always_comb begin
        case (rom_row)
            3'd0, 3'd7: rom_bits = 8'h3C;
            3'd1, 3'd6: rom_bits = 8'h7E;
            default:    rom_bits = 8'hFF;
        endcase
    end
    assign ball_on = ball_box && rom_bits[rom_col];
`else
    assign ball_on = ball_box;
`endif

    assign pad_on = (pix_x >= L_X0 && pix_x <= L_X1 && pix_y >= bar_l && pix_y <= bar_l_b) ||
                    (pix_x >= R_X0 && pix_x <= R_X1 && pix_y >= bar_r && pix_y <= bar_r_b);

    always_comb begin
        rgb_nxt = 3'b110;
        if (!video_on)
            rgb_nxt = 3'b000;
        else if (pad_on)
            rgb_nxt = 3'b010;
        else if (ball_on)
            rgb_nxt = 3'b100;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_SERVE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x_l       <= BALL_X0;
            y_t       <= BALL_Y0;
            dir_r     <= 1'b1;
            dir_d     <= 1'b1;
            bar_l     <= BAR_INIT;
            bar_r     <= BAR_INIT;
            cnt       <= '0;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            graph_rgb <= 3'b000;
        end else begin
            x_l       <= x_nxt;
            y_t       <= y_nxt;
            dir_r     <= dx_nxt;
            dir_d     <= dy_nxt;
            bar_l     <= bar_l_nxt;
            bar_r     <= bar_r_nxt;
            cnt       <= cnt_nxt;
            score_l   <= sl_nxt;
            score_r   <= sr_nxt;
            hit       <= hit_nxt;
            miss      <= miss_nxt;
            graph_rgb <= rgb_nxt;
        end
    end
endmodule
